// File: rtl/frame_strobe_sequencer.sv
// Writes a run of configuration words into consecutive frame latches of one tile column,
// with setup/strobe/hold timing around each transparent-latch write.
module frame_strobe_sequencer #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned SetupCycles     = 1,
  parameter int unsigned StrobeCycles    = 2,
  parameter int unsigned HoldCycles      = 1,
  localparam int unsigned AW = $clog2(MaxFramesPerCol),
  localparam int unsigned CW = $clog2(MaxFramesPerCol + 1)
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [AW-1:0]              base_frame,
  input  logic [CW-1:0]              num_frames,
  input  logic                       abort,
  input  logic                       word_valid,
  input  logic [FrameBitsPerRow-1:0] word_data,
  output logic                       word_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned SetStr   = (SetupCycles > StrobeCycles) ? SetupCycles : StrobeCycles;
  localparam int unsigned MaxPhase = (SetStr > HoldCycles) ? SetStr : HoldCycles;
  localparam int unsigned PW       = $clog2(MaxPhase + 1);

  typedef enum logic [2:0] {
    Idle,
    WaitWord,
    Setup,
    Strobe,
    Hold
  } state_t;

  state_t          state;
  logic [PW-1:0]   phaseCnt;
  logic [AW-1:0]   frameIdx;
  logic [CW-1:0]   framesLeft;
  logic [CW:0]     runEnd;
  logic            startOk;

  // Range check uses one extra bit so base+num cannot overflow.
  assign runEnd  = (CW+1)'(base_frame) + (CW+1)'(num_frames);
  assign startOk = (num_frames != '0) && (runEnd <= (CW+1)'(MaxFramesPerCol));

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state       <= Idle;
      phaseCnt    <= '0;
      frameIdx    <= '0;
      framesLeft  <= '0;
      word_ready  <= 1'b0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (abort && (state != Idle)) begin
        // Abort drops the strobe immediately; FrameData is left as is.
        state       <= Idle;
        phaseCnt    <= '0;
        word_ready  <= 1'b0;
        FrameStrobe <= '0;
        busy        <= 1'b0;
      end else begin
        case (state)
          Idle: begin
            if (start && !abort) begin
              if (startOk) begin
                frameIdx   <= base_frame;
                framesLeft <= num_frames;
                busy       <= 1'b1;
                word_ready <= 1'b1;
                state      <= WaitWord;
              end else begin
                error <= 1'b1;
              end
            end
          end
          WaitWord: begin
            if (word_valid && word_ready) begin
              FrameData  <= word_data;
              word_ready <= 1'b0;
              phaseCnt   <= '0;
              state      <= Setup;
            end
          end
          Setup: begin
            if (phaseCnt == PW'(SetupCycles - 1)) begin
              phaseCnt    <= '0;
              FrameStrobe <= MaxFramesPerCol'(1) << frameIdx;
              state       <= Strobe;
            end else begin
              phaseCnt <= phaseCnt + PW'(1);
            end
          end
          Strobe: begin
            if (phaseCnt == PW'(StrobeCycles - 1)) begin
              phaseCnt    <= '0;
              FrameStrobe <= '0;
              state       <= Hold;
            end else begin
              phaseCnt <= phaseCnt + PW'(1);
            end
          end
          Hold: begin
            if (phaseCnt == PW'(HoldCycles - 1)) begin
              phaseCnt   <= '0;
              framesLeft <= framesLeft - CW'(1);
              if (framesLeft == CW'(1)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= Idle;
              end else begin
                frameIdx   <= frameIdx + AW'(1);
                word_ready <= 1'b1;
                state      <= WaitWord;
              end
            end else begin
              phaseCnt <= phaseCnt + PW'(1);
            end
          end
          default: state <= Idle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Randomised scoreboard bench for frame_strobe_sequencer: expected frame writes are queued at
// issue time and a negedge monitor checks every strobe pulse against them.
module tb_frame_strobe_sequencer;

  localparam int unsigned NF  = 20;
  localparam int unsigned FW  = 32;
  localparam int unsigned SC  = 1;
  localparam int unsigned STC = 2;
  localparam int unsigned HC  = 1;
  localparam int unsigned AW  = $clog2(NF);
  localparam int unsigned CW  = $clog2(NF + 1);

  logic          CLK = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_frame = '0;
  logic [CW-1:0] num_frames = '0;
  logic          abort = 1'b0;
  logic          word_valid = 1'b0;
  logic [FW-1:0] word_data = '0;
  logic          word_ready;
  logic [FW-1:0] FrameData;
  logic [NF-1:0] FrameStrobe;
  logic          busy;
  logic          done;
  logic          error;

  frame_strobe_sequencer #(
    .MaxFramesPerCol(NF), .FrameBitsPerRow(FW),
    .SetupCycles(SC), .StrobeCycles(STC), .HoldCycles(HC)
  ) dut (
    .CLK(CLK), .resetn(resetn), .start(start), .base_frame(base_frame),
    .num_frames(num_frames), .abort(abort), .word_valid(word_valid),
    .word_data(word_data), .word_ready(word_ready), .FrameData(FrameData),
    .FrameStrobe(FrameStrobe), .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    int            idx;
    logic [FW-1:0] data;
    int            width;   // 0: pulse cut by reset, width not checked
  } exp_t;

  exp_t          expQ[$];
  int            hsQ[$];
  int            hsLog[$];
  logic [FW-1:0] wordQ[$];
  logic [FW-1:0] refMem[NF];
  logic [FW-1:0] latchMem[NF];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int expDone = 0, obsDone = 0, expErr = 0, obsErr = 0;
  bit holdOff = 1'b0;
  bit randStall = 1'b0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word source: presents queued words, records the edge of every handshake.
  initial begin
    bit hs;
    forever begin
      @(negedge CLK);
      hs = resetn && word_valid && word_ready && !abort;
      @(posedge CLK);
      #1;
      if (hs && wordQ.size() > 0) begin
        void'(wordQ.pop_front());
        hsQ.push_back(cyc);
        hsLog.push_back(cyc);
      end
      if (wordQ.size() > 0 && !holdOff && (!randStall || $urandom_range(0, 3) != 0)) begin
        word_valid = 1'b1;
        word_data  = wordQ[0];
      end else begin
        word_valid = 1'b0;
      end
    end
  end

  // Monitor: strobe pulses against the expected queue, plus a transparent-latch model.
  logic [NF-1:0] prevStrobe = '0;
  logic [FW-1:0] prevData = '0;
  int            width = 0;
  int            curWidth = 0;
  exp_t          eMon;
  int            hMon;

  always @(negedge CLK) begin
    if (!resetn) begin
      prevStrobe = '0;
      width = 0;
    end else begin
      if (done) obsDone++;
      if (error) obsErr++;
      if (FrameStrobe != '0) begin
        check($onehot(FrameStrobe), "strobe_onehot", 64'(FrameStrobe), 64'(FrameStrobe));
        if (prevStrobe == '0) begin
          check(expQ.size() != 0, "unexpected_strobe", 64'(FrameStrobe), 64'(0));
          if (expQ.size() != 0) begin
            eMon = expQ.pop_front();
            check(FrameStrobe == (NF'(1) << eMon.idx), "strobe_index", 64'(FrameStrobe), 64'(NF'(1) << eMon.idx));
            check(FrameData == eMon.data, "frame_data", 64'(FrameData), 64'(eMon.data));
            curWidth = eMon.width;
          end
          check(hsQ.size() != 0, "strobe_without_handshake", 64'(cyc), 64'(0));
          if (hsQ.size() != 0) begin
            hMon = hsQ.pop_front();
            check(cyc == hMon + int'(SC), "strobe_rise_cycle", 64'(cyc), 64'(hMon + int'(SC)));
          end
          width = 1;
        end else begin
          width++;
          check(FrameStrobe == prevStrobe && FrameData == prevData, "strobe_stable",
                64'(FrameData), 64'(prevData));
        end
        for (int i = 0; i < int'(NF); i++)
          if (FrameStrobe[i]) latchMem[i] = FrameData;
      end else if (prevStrobe != '0 && curWidth != 0) begin
        check(width == curWidth, "strobe_width", 64'(width), 64'(curWidth));
      end
      prevStrobe = FrameStrobe;
      prevData   = FrameData;
    end
  end

  // Issue one run. Frames past cutAt are not expected; frame cutAt gets width cutWidth.
  task automatic issueRun(input int base, input int num, input int cutAt, input int cutWidth);
    bit ok;
    logic [FW-1:0] w;
    ok = (num != 0) && (base + num <= int'(NF));
    if (ok) begin
      for (int i = 0; i < num; i++) begin
        if (cutAt >= 0 && i > cutAt) break;
        w = $urandom();
        expQ.push_back('{idx: base + i, data: w, width: (i == cutAt) ? cutWidth : int'(STC)});
        refMem[base + i] = w;
        wordQ.push_back(w);
      end
      if (cutAt < 0) expDone++;
    end else begin
      expErr++;
    end
    @(posedge CLK); #1;
    start = 1'b1;
    base_frame = AW'(base);
    num_frames = CW'(num);
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    if (ok) begin
      check(busy == 1'b1, "busy_after_start", 64'(busy), 64'(1));
      check(error == 1'b0, "no_error_on_accept", 64'(error), 64'(0));
    end else begin
      check(error == 1'b1, "error_on_reject", 64'(error), 64'(1));
      check(busy == 1'b0, "busy_on_reject", 64'(busy), 64'(0));
    end
  endtask

  task automatic waitRunEnd(input int budget);
    int n = 0;
    while ((obsDone != expDone || obsErr != expErr || expQ.size() != 0 || busy) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    check(n < budget, "run_timeout", 64'(n), 64'(budget));
    check(obsDone == expDone, "done_count", 64'(obsDone), 64'(expDone));
    check(obsErr == expErr, "error_count", 64'(obsErr), 64'(expErr));
  endtask

  task automatic checkResetOutputs(input string tag);
    check(FrameStrobe == '0 && word_ready == 1'b0 && busy == 1'b0 && done == 1'b0 &&
          error == 1'b0 && FrameData == '0, tag,
          64'({FrameStrobe, word_ready, busy, done, error}), 64'(0));
  endtask

  initial begin
    int n;
    for (int i = 0; i < int'(NF); i++) begin
      refMem[i] = '0;
      latchMem[i] = '0;
    end

    // Reset values
    repeat (2) @(negedge CLK);
    checkResetOutputs("reset_outputs");
    @(posedge CLK); #1;
    resetn = 1'b1;
    repeat (2) @(negedge CLK);

    // Two frames from base 0 with fixed words, back to back
    hsLog.delete();
    expQ.push_back('{idx: 0, data: 32'hDEADBEEF, width: int'(STC)});
    expQ.push_back('{idx: 1, data: 32'h12345678, width: int'(STC)});
    refMem[0] = 32'hDEADBEEF;
    refMem[1] = 32'h12345678;
    wordQ.push_back(32'hDEADBEEF);
    wordQ.push_back(32'h12345678);
    expDone++;
    @(posedge CLK); #1;
    start = 1'b1; base_frame = AW'(0); num_frames = CW'(2);
    @(posedge CLK); #1;
    start = 1'b0;
    waitRunEnd(200);
    check(hsLog.size() == 2, "handshake_count", 64'(hsLog.size()), 64'(2));
    if (hsLog.size() == 2)
      check(hsLog[1] - hsLog[0] == int'(1 + SC + STC + HC), "word_spacing",
            64'(hsLog[1] - hsLog[0]), 64'(1 + SC + STC + HC));

    // Range boundaries
    issueRun(18, 2, -1, 0);
    waitRunEnd(200);
    issueRun(19, 2, -1, 0);
    waitRunEnd(50);
    issueRun(0, 0, -1, 0);
    waitRunEnd(50);

    // Backpressure in WAIT_WORD
    holdOff = 1'b1;
    issueRun(7, 1, -1, 0);
    for (int i = 0; i < 7; i++) begin
      check(word_ready == 1'b1 && FrameStrobe == '0, "stall_idle",
            64'({word_ready, FrameStrobe}), 64'({1'b1, NF'(0)}));
      @(negedge CLK);
    end
    holdOff = 1'b0;
    waitRunEnd(200);

    // Abort during the first strobe cycle of frame 3
    issueRun(0, 5, 3, 1);
    n = 0;
    while (!FrameStrobe[3] && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(n < 200, "abort_wait_timeout", 64'(n), 64'(200));
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    wordQ.delete();
    @(negedge CLK);
    check(FrameStrobe == '0 && busy == 1'b0 && word_ready == 1'b0, "abort_outputs",
          64'({FrameStrobe, busy, word_ready}), 64'(0));
    waitRunEnd(50);
    issueRun(3, 1, -1, 0);
    waitRunEnd(200);

    // Abort together with start in IDLE: start ignored, no error
    @(posedge CLK); #1;
    start = 1'b1; abort = 1'b1; base_frame = AW'(19); num_frames = CW'(5);
    @(posedge CLK); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge CLK);
    check(busy == 1'b0 && error == 1'b0, "abort_start_idle", 64'({busy, error}), 64'(0));
    waitRunEnd(50);

    // Randomised runs with random valid gaps
    randStall = 1'b1;
    for (int r = 0; r < 10; r++) begin
      issueRun(int'($urandom_range(0, NF - 1)), int'($urandom_range(0, 5)), -1, 0);
      waitRunEnd(400);
    end
    randStall = 1'b0;

    // Reset asserted mid-strobe
    issueRun(5, 1, 0, 0);
    n = 0;
    while (FrameStrobe == '0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(n < 200, "reset_wait_timeout", 64'(n), 64'(200));
    #2;
    resetn = 1'b0;
    #1;
    checkResetOutputs("reset_mid_strobe");
    wordQ.delete();
    hsQ.delete();
    repeat (2) @(posedge CLK);
    #1;
    resetn = 1'b1;
    @(negedge CLK);
    checkResetOutputs("after_reset_release");
    issueRun(10, 2, -1, 0);
    waitRunEnd(200);

    // Latch contents against the reference memory
    for (int i = 0; i < int'(NF); i++)
      check(latchMem[i] == refMem[i], $sformatf("latch_frame_%0d", i), 64'(latchMem[i]), 64'(refMem[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
